// File: rtl/sd_image_arbiter_if.sv
// sd_image_arbiter_if
//   Bundles the client-side request bus and the host I/O side handshake
//   of the SD image arbiter.
//   Ports (signals):
//     reqRd/reqWr   [CHANNELS]     per-client read/write request levels
//     reqLba        [32*CHANNELS]  per-client LBA, channel i at [32*i+31:32*i]
//     reqBuffD      [8*CHANNELS]   per-client write-buffer byte
//     reqAck        [CHANNELS]     per-client acknowledge
//     sdRd/sdWr     [CHANNELS]     request towards the host I/O block
//     sdAck                        transfer acknowledge from the host I/O block
//     sdLba         [32]           LBA of the granted channel
//     sdBuffD       [8]            buffer byte of the granted channel
//     busy, grant[3], tmo          arbiter status
//   Modports: master = arbiter side, slave = clients + host I/O side.
interface sd_image_arbiter_if #(
   parameter int CHANNELS = 3
);
   logic [CHANNELS-1:0]    reqRd;
   logic [CHANNELS-1:0]    reqWr;
   logic [32*CHANNELS-1:0] reqLba;
   logic [8*CHANNELS-1:0]  reqBuffD;
   logic [CHANNELS-1:0]    reqAck;
   logic [CHANNELS-1:0]    sdRd;
   logic [CHANNELS-1:0]    sdWr;
   logic                   sdAck;
   logic [31:0]            sdLba;
   logic [7:0]             sdBuffD;
   logic                   busy;
   logic [2:0]             grant;
   logic                   tmo;

   modport master (
      input  reqRd, reqWr, reqLba, reqBuffD, sdAck,
      output reqAck, sdRd, sdWr, sdLba, sdBuffD, busy, grant, tmo
   );

   modport slave (
      output reqRd, reqWr, reqLba, reqBuffD, sdAck,
      input  reqAck, sdRd, sdWr, sdLba, sdBuffD, busy, grant, tmo
   );
endinterface

// File: rtl/sd_image_arbiter.sv
// sd_image_arbiter
//   Round-robin arbiter that shares one host I/O sector channel between
//   up to 8 image clients. FSM: IDLE -> REQ -> XFER -> DONE -> IDLE.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-low
//     bus    sd_image_arbiter_if.master (client requests, host handshake,
//            status busy/grant/tmo)
//   Parameters: CHANNELS (1..8), TIMEOUT (REQ cycles before abort, 0 = off),
//               TOW (timeout counter width).
module sd_image_arbiter #(
   parameter int CHANNELS = 3,
   parameter int TIMEOUT  = 16777215,
   parameter int TOW      = 24
) (
   input logic                clock,
   input logic                reset,
   sd_image_arbiter_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] XFER = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [2:0]     LASTCH  = 3'(CHANNELS - 1);
   localparam logic [TOW-1:0] TMOLAST = TOW'(TIMEOUT - 1);
   localparam bit             TMOEN   = (TIMEOUT != 0);

   logic [1:0]          stateReg;
   logic [2:0]          ptrReg;
   logic [2:0]          grantReg;
   logic [31:0]         lbaReg;
   logic                dirWrReg;
   logic [CHANNELS-1:0] sdRdReg;
   logic [CHANNELS-1:0] sdWrReg;
   logic [TOW-1:0]      tmoCntReg;
   logic                tmoReg;

   // Per-channel views padded to 8 entries so a 3-bit index is always in range.
   logic [7:0]  pend8;
   logic [7:0]  wr8;
   logic [31:0] lbaArr  [8];
   logic [7:0]  buffArr [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_chan
         if (gi < CHANNELS) begin : g_used
            assign pend8[gi]   = bus.reqRd[gi] | bus.reqWr[gi];
            assign wr8[gi]     = bus.reqWr[gi];
            assign lbaArr[gi]  = bus.reqLba[32*gi +: 32];
            assign buffArr[gi] = bus.reqBuffD[8*gi +: 8];
         end else begin : g_unused
            assign pend8[gi]   = 1'b0;
            assign wr8[gi]     = 1'b0;
            assign lbaArr[gi]  = 32'd0;
            assign buffArr[gi] = 8'd0;
         end
      end
   endgenerate

   // Round-robin pick: first pending channel at ptr, ptr+1, ... with wrap.
   // The scan runs from the farthest offset down so the nearest one wins.
   logic       anyPend;
   logic [2:0] pick;
   logic [3:0] idxSum;

   always_comb begin
      anyPend = 1'b0;
      pick    = ptrReg;
      idxSum  = 4'd0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         idxSum = {1'b0, ptrReg} + 4'(k);
         if (idxSum >= 4'(CHANNELS)) begin
            idxSum = idxSum - 4'(CHANNELS);
         end
         if (pend8[idxSum[2:0]]) begin
            anyPend = 1'b1;
            pick    = idxSum[2:0];
         end
      end
   end

   logic [CHANNELS-1:0] grantHot;
   logic [CHANNELS-1:0] rdHot;
   logic [CHANNELS-1:0] wrHot;
   logic [2:0]          nextPtr;

   assign grantHot = CHANNELS'(1) << grantReg;
   assign rdHot    = dirWrReg ? '0 : grantHot;
   assign wrHot    = dirWrReg ? grantHot : '0;
   assign nextPtr  = (grantReg == LASTCH) ? 3'd0 : grantReg + 3'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg  <= IDLE;
         ptrReg    <= 3'd0;
         grantReg  <= 3'd0;
         lbaReg    <= 32'd0;
         dirWrReg  <= 1'b0;
         sdRdReg   <= '0;
         sdWrReg   <= '0;
         tmoCntReg <= '0;
         tmoReg    <= 1'b0;
      end else begin
         tmoReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               // Direction and LBA are frozen here; later client changes
               // are ignored until the next grant.
               if (anyPend) begin
                  grantReg  <= pick;
                  lbaReg    <= lbaArr[pick];
                  dirWrReg  <= wr8[pick];
                  tmoCntReg <= '0;
                  stateReg  <= REQ;
               end
            end
            REQ: begin
               if (bus.sdAck) begin
                  // Keep the request bit up for the whole acknowledge.
                  sdRdReg  <= rdHot;
                  sdWrReg  <= wrHot;
                  stateReg <= XFER;
               end else if (!pend8[grantReg]) begin
                  // Client withdrew: back to IDLE, ptr untouched.
                  sdRdReg  <= '0;
                  sdWrReg  <= '0;
                  stateReg <= IDLE;
               end else if (TMOEN && (tmoCntReg == TMOLAST)) begin
                  sdRdReg  <= '0;
                  sdWrReg  <= '0;
                  tmoReg   <= 1'b1;
                  ptrReg   <= nextPtr;
                  stateReg <= IDLE;
               end else begin
                  tmoCntReg <= tmoCntReg + TOW'(1);
                  sdRdReg   <= rdHot;
                  sdWrReg   <= wrHot;
               end
            end
            XFER: begin
               if (!bus.sdAck) begin
                  sdRdReg  <= '0;
                  sdWrReg  <= '0;
                  ptrReg   <= nextPtr;
                  stateReg <= DONE;
               end
            end
            default: begin
               // DONE: wait for the served client to drop its level so the
               // same request is never granted twice.
               if (!pend8[grantReg]) begin
                  stateReg <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.reqAck  = (((stateReg == REQ) || (stateReg == XFER)) && bus.sdAck)
                        ? grantHot : '0;
   assign bus.sdRd    = sdRdReg;
   assign bus.sdWr    = sdWrReg;
   assign bus.sdLba   = lbaReg;
   assign bus.sdBuffD = buffArr[grantReg];
   assign bus.busy    = (stateReg != IDLE);
   assign bus.grant   = grantReg;
   assign bus.tmo     = tmoReg;

endmodule

// File: tb/tb_sd_image_arbiter.sv
// tb_sd_image_arbiter
//   Directed bench for sd_image_arbiter (CHANNELS=3, TIMEOUT=8): reset
//   state, single read, round robin, write priority, timeout, withdraw and
//   reset during a transfer.
module tb_sd_image_arbiter;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   sd_image_arbiter_if #(.CHANNELS(3)) bus ();

   sd_image_arbiter #(
      .CHANNELS(3),
      .TIMEOUT (8),
      .TOW     (24)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   // One round-robin service: wait for the request, ack it, let the client
   // drop its bit in DONE, then re-raise it.
   task automatic rrStep(input logic [2:0] expG);
      int         n;
      logic [2:0] g;
      n = 0;
      while (((bus.sdRd | bus.sdWr) == 3'b000) && (n < 8)) begin
         tick();
         n++;
      end
      chk("rr_wait", 32'(n < 8), 32'd1);
      g = bus.grant;
      chk("rr_grant", 32'(g), 32'(expG));
      chk("rr_sdRd", 32'(bus.sdRd), 32'(3'b001 << expG));
      bus.sdAck = 1'b1;
      tick();
      tick();
      bus.sdAck = 1'b0;
      tick();
      bus.reqRd[g] = 1'b0;
      tick();
      bus.reqRd[g] = 1'b1;
   endtask

   logic [2:0] rrExp [4];
   int         ackMiss;

   initial begin
      total = 0;
      bad   = 0;
      rrExp = '{3'd0, 3'd1, 3'd2, 3'd0};

      reset        = 1'b0;
      bus.reqRd    = 3'b000;
      bus.reqWr    = 3'b000;
      bus.reqLba   = '0;
      bus.reqBuffD = {8'hC3, 8'hB2, 8'hA1};
      bus.sdAck    = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_busy",  32'(bus.busy),   32'd0);
      chk("rst_grant", 32'(bus.grant),  32'd0);
      chk("rst_lba",   bus.sdLba,       32'd0);
      chk("rst_sd",    32'({bus.sdRd, bus.sdWr}), 32'd0);
      chk("rst_ack",   32'(bus.reqAck), 32'd0);
      chk("rst_tmo",   32'(bus.tmo),    32'd0);
      reset = 1'b1;

      // single read
      bus.reqRd         = 3'b001;
      bus.reqLba[31:0]  = 32'h12;
      tick();
      chk("rd_busy",  32'(bus.busy), 32'd1);
      chk("rd_sdRd0", 32'(bus.sdRd), 32'd0);
      tick();
      chk("rd_sdRd",  32'(bus.sdRd), 32'b001);
      chk("rd_lba",   bus.sdLba,     32'h12);
      chk("rd_buff",  32'(bus.sdBuffD), 32'hA1);
      bus.sdAck        = 1'b1;
      bus.reqLba[31:0] = 32'h99;
      #1;
      chk("rd_ack_on", 32'(bus.reqAck), 32'b001);
      ackMiss = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         if ((bus.reqAck !== 3'b001) || (bus.sdRd !== 3'b001)) ackMiss++;
      end
      chk("rd_ack_follow", 32'(ackMiss), 32'd0);
      bus.sdAck = 1'b0;
      #1;
      chk("rd_ack_off", 32'(bus.reqAck), 32'd0);
      tick();
      chk("rd_done_sdRd", 32'(bus.sdRd), 32'd0);
      chk("rd_done_lba",  bus.sdLba,     32'h12);
      bus.sdAck = 1'b1;
      tick();
      chk("rd_done_hold", 32'(bus.busy),   32'd1);
      chk("rd_done_ack",  32'(bus.reqAck), 32'd0);
      bus.sdAck = 1'b0;
      bus.reqRd = 3'b000;
      tick();
      chk("rd_idle", 32'(bus.busy), 32'd0);

      // round robin
      doReset();
      bus.reqRd = 3'b111;
      for (int i = 0; i < 4; i++) rrStep(rrExp[i]);
      bus.reqRd = 3'b000;
      tick();
      tick();
      chk("rr_idle", 32'(bus.busy), 32'd0);

      // write priority
      doReset();
      bus.reqRd = 3'b010;
      bus.reqWr = 3'b010;
      tick();
      tick();
      chk("wp_sdWr",  32'(bus.sdWr),    32'b010);
      chk("wp_sdRd",  32'(bus.sdRd),    32'b000);
      chk("wp_grant", 32'(bus.grant),   32'd1);
      chk("wp_buff",  32'(bus.sdBuffD), 32'hB2);
      bus.reqRd = 3'b000;
      bus.reqWr = 3'b000;
      tick();
      chk("wp_idle", 32'(bus.busy), 32'd0);

      // timeout
      doReset();
      bus.reqWr = 3'b100;
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("to_pre_tmo",  32'(bus.tmo),  32'd0);
      chk("to_pre_sdWr", 32'(bus.sdWr), 32'b100);
      tick();
      chk("to_tmo",  32'(bus.tmo),  32'd1);
      chk("to_sdWr", 32'(bus.sdWr), 32'd0);
      chk("to_busy", 32'(bus.busy), 32'd0);
      bus.reqRd = 3'b001;
      tick();
      chk("to_pulse", 32'(bus.tmo),   32'd0);
      chk("to_next",  32'(bus.grant), 32'd0);
      bus.reqRd = 3'b000;
      bus.reqWr = 3'b000;
      tick();
      chk("to_idle", 32'(bus.busy), 32'd0);

      // withdraw
      doReset();
      bus.reqRd = 3'b001;
      tick();
      tick();
      bus.reqRd = 3'b000;
      #1;
      chk("wd_ack", 32'(bus.reqAck), 32'd0);
      tick();
      chk("wd_busy", 32'(bus.busy), 32'd0);
      chk("wd_sdRd", 32'(bus.sdRd), 32'd0);
      bus.reqRd = 3'b011;
      tick();
      chk("wd_ptr", 32'(bus.grant), 32'd0);
      bus.reqRd = 3'b000;
      tick();

      // reset during XFER
      doReset();
      bus.reqRd = 3'b010;
      tick();
      tick();
      bus.sdAck = 1'b1;
      tick();
      chk("rx_ack", 32'(bus.reqAck), 32'b010);
      reset = 1'b0;
      #1;
      chk("rx_busy",  32'(bus.busy),   32'd0);
      chk("rx_ack0",  32'(bus.reqAck), 32'd0);
      chk("rx_sd",    32'({bus.sdRd, bus.sdWr}), 32'd0);
      chk("rx_grant", 32'(bus.grant),  32'd0);
      chk("rx_lba",   bus.sdLba,       32'd0);
      chk("rx_tmo",   32'(bus.tmo),    32'd0);
      bus.sdAck = 1'b0;
      bus.reqRd = 3'b011;
      reset     = 1'b1;
      tick();
      chk("rx_regrant", 32'(bus.grant), 32'd0);
      chk("rx_tmo2",    32'(bus.tmo),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_image_arbiter.md
SD_IMAGE_ARBITER -- requirements
Module: sd_image_arbiter

Interface
REQ-001 Parameter CHANNELS, default 3: number of image clients (1..8).
REQ-002 Parameter TIMEOUT, default 16777215: REQ-state cycles without sdAck before abort; 0 disables the timeout.
REQ-003 Parameter TOW, default 24: width of the timeout counter.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 reqRd  in  CHANNELS  per-client sector read request, level.
REQ-007 reqWr  in  CHANNELS  per-client sector write request, level.
REQ-008 reqLba  in  32*CHANNELS  per-client LBA, flattened; channel i is bits [32*i+31:32*i].
REQ-009 reqBuffD  in  8*CHANNELS  per-client write-buffer byte, flattened the same way.
REQ-010 reqAck  out  CHANNELS  per-client acknowledge.
REQ-011 sdRd  out  CHANNELS  read request to the host I/O block.
REQ-012 sdWr  out  CHANNELS  write request to the host I/O block.
REQ-013 sdAck  in  1  transfer acknowledge from the host I/O block.
REQ-014 sdLba  out  32  LBA latched for the granted channel.
REQ-015 sdBuffD  out  8  reqBuffD byte of the granted channel.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant  out  3  index of the granted channel; holds the last value when idle.
REQ-018 tmo  out  1  one-cycle pulse when a request is aborted by timeout.

Function
REQ-019 The arbiter SHALL run a 4-state FSM: IDLE, REQ, XFER, DONE.
REQ-020 IDLE: a channel is pending when reqRd[i]|reqWr[i]; the arbiter SHALL pick the first pending channel scanning from pointer ptr upward with wrap, load grant, latch sdLba=reqLba[grant] and latch the direction, then enter REQ the next cycle.
REQ-021 Direction SHALL be sampled at grant time; when reqRd and reqWr are both high, write wins.
REQ-022 REQ: sdRd[grant] or sdWr[grant] SHALL be high (one bit only, registered); all other sdRd/sdWr bits SHALL be 0.
REQ-023 REQ to XFER on sdAck=1; the request bit stays asserted while sdAck is high.
REQ-024 REQ to IDLE, without advancing ptr, if the client drops both its request bits before sdAck.
REQ-025 REQ timeout: a counter SHALL be cleared on REQ entry; when it reaches TIMEOUT (TIMEOUT≠0) the arbiter SHALL pulse tmo, drop sdRd/sdWr, set ptr=grant+1 mod CHANNELS and enter IDLE.
REQ-026 XFER to DONE on sdAck=0; sdRd/sdWr SHALL be 0 in DONE.
REQ-027 DONE: ptr SHALL be set to grant+1 mod CHANNELS; the arbiter returns to IDLE only once reqRd[grant] and reqWr[grant] are both 0, so a stale level is never granted twice.
REQ-028 reqAck[grant] SHALL equal sdAck combinationally in REQ and XFER; it SHALL be 0 for every other channel and in every other state.
REQ-029 sdBuffD SHALL be combinational reqBuffD[grant] in all states.
REQ-030 sdLba SHALL stay stable from IDLE exit until the next grant; client LBA changes during REQ/XFER SHALL be ignored.
REQ-031 sdAck high while in IDLE or DONE SHALL be ignored.
REQ-032 Grant-to-sdRd latency SHALL be 1 cycle from the request edge when idle, plus 1 cycle for the REQ-state register.

Reset
REQ-033 While reset=0: state=IDLE, ptr=0, grant=0, sdLba=0, sdRd=sdWr=0, reqAck=0, busy=0, tmo=0, timeout counter=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately with no pulse on tmo.

Verification
REQ-035 Single read: reqRd=3'b001, reqLba0=0x12 -> 2 cycles later sdRd=001, sdLba=0x12; sdAck 1 for 512 cycles -> reqAck[0] follows it; client drops req -> IDLE, busy=0.
REQ-036 Round robin: reqRd=3'b111 held and re-raised after each ack -> grant sequence 0,1,2,0.
REQ-037 Write priority: reqRd[1]=reqWr[1]=1 -> sdWr=010, sdRd=000.
REQ-038 Timeout, TIMEOUT=8: reqWr[2] with no sdAck -> tmo pulses 8 cycles after REQ entry, sdWr=0, then channel 0 is granted before channel 2 when both are pending.
REQ-039 Withdraw: reqRd[0] dropped in REQ before sdAck -> IDLE next cycle, ptr unchanged, no reqAck.
REQ-040 Reset mid-XFER: reset low with sdAck=1 -> all outputs 0 asynchronously; after release, a pending request is granted from channel 0.
